// File: rtl/bf_cell_sequencer_pkg.sv
// Shared types and defaults for the run-length data-cell sequencer.
// Optional build macro CELL_SAT_EN (saturating arithmetic) is consumed by bf_cell_sequencer.
package bf_cell_sequencer_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int ADDR_W_DEF = 15;
    localparam int CNT_W_DEF  = 8;

    // Command opcodes; OP_RSV behaves exactly like OP_NOP (read only).
    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_INC = 2'b01,
        OP_DEC = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    // Sequencer states, kept as plain constants so legacy tools can map them.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_APPLY = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    // True for opcodes that actually step the ALU.
    function automatic logic op_is_step(input logic [1:0] op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/bf_cell_sequencer_if.sv
// Bundle of command, data-RAM and ALU signals around the cell sequencer.
// master = the sequencer itself, slave = decode stage + RAM + ALU at the parent.
interface bf_cell_sequencer_if #(
    parameter int WIDTH  = bf_cell_sequencer_pkg::WIDTH_DEF,
    parameter int ADDR_W = bf_cell_sequencer_pkg::ADDR_W_DEF,
    parameter int CNT_W  = bf_cell_sequencer_pkg::CNT_W_DEF
) ();

    // command handshake
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [CNT_W-1:0]  cmd_count;

    // data RAM
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [WIDTH-1:0]  mem_rdata;
    logic              mem_we;
    logic [WIDTH-1:0]  mem_wdata;

    // ALU
    logic [WIDTH-1:0]  alu_a;
    logic              alu_nochange;
    logic              alu_decrement;
    logic              alu_increment;
    logic [WIDTH-1:0]  alu_out;

    // completion
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              sat_hit;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_count, mem_rdata, alu_out,
        output cmd_ready, mem_addr, mem_re, mem_we, mem_wdata,
               alu_a, alu_nochange, alu_decrement, alu_increment,
               done, result, sat_hit
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_count, mem_rdata, alu_out,
        input  cmd_ready, mem_addr, mem_re, mem_we, mem_wdata,
               alu_a, alu_nochange, alu_decrement, alu_increment,
               done, result, sat_hit
    );

endinterface

// File: rtl/bf_cell_sequencer.sv
// Read-modify-write sequencer for one run-length data-cell command:
// READ the cell, step the external ALU N times, WRITE the cell back.
// Build macro CELL_SAT_EN: clip at 0 / all-ones instead of wrapping, report sat_hit.
module bf_cell_sequencer
    import bf_cell_sequencer_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bf_cell_sequencer_if.master   bus
);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    op_e               r_op;
    logic              r_step;      // op really modifies the cell (INC/DEC with count != 0)
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_result;

    logic              w_accept;
    logic              w_sat_now;
    logic              w_inc;
    logic              w_dec;
    logic              w_skip_load;
    logic              w_done;
    logic [WIDTH-1:0]  w_done_value;

    assign w_accept = bus.cmd_valid & bus.cmd_ready;

`ifdef CELL_SAT_EN
    logic r_sat;

    // Acc already sits on the bound in the direction of travel: hold instead of wrapping.
    assign w_sat_now = (r_state == ST_APPLY) &&
                       (((r_op == OP_INC) && (r_acc == {WIDTH{1'b1}})) ||
                        ((r_op == OP_DEC) && (r_acc == {WIDTH{1'b0}})));

    // Sticky clip flag for the op in flight, cleared when the next command is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_sat <= 1'b0;
        end else if (w_sat_now) begin
            r_sat <= 1'b1;
        end
    end

    assign bus.sat_hit = r_sat;
`else
    assign w_sat_now   = 1'b0;
    assign bus.sat_hit = 1'b0;
`endif

    // A non-modifying op finishes in LOAD straight from the RAM data; WRITE then stays quiet.
    assign w_skip_load  = (r_state == ST_LOAD) && !r_step;
    assign w_done       = w_skip_load || ((r_state == ST_WRITE) && r_step);
    assign w_done_value = w_skip_load ? bus.mem_rdata : r_acc;

    // ALU controls: exactly one of the three is high in every cycle.
    assign w_inc = (r_state == ST_APPLY) && (r_op == OP_INC) && !w_sat_now;
    assign w_dec = (r_state == ST_APPLY) && (r_op == OP_DEC) && !w_sat_now;

    // Next-state decode for IDLE -> READ -> LOAD -> (APPLY) -> WRITE -> IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_READ;
            ST_READ:  w_state_next = ST_LOAD;
            ST_LOAD:  w_state_next = r_step ? ST_APPLY : ST_WRITE;
            ST_APPLY: if (r_cnt == CNT_W'(1)) w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // State register; reset in any state aborts the op before it can write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command latch, accumulator, down-counter and held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_NOP;
            r_step   <= 1'b0;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= op_e'(bus.cmd_op);
                r_step <= op_is_step(bus.cmd_op) && (bus.cmd_count != '0);
                r_addr <= bus.cmd_addr;
                r_cnt  <= bus.cmd_count;
            end
            if (r_state == ST_LOAD) begin
                r_acc <= bus.mem_rdata;
            end
            if (r_state == ST_APPLY) begin
                r_acc <= w_sat_now ? r_acc : bus.alu_out;
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_done) begin
                r_result <= w_done_value;
            end
        end
    end

    assign bus.cmd_ready     = (r_state == ST_IDLE);
    assign bus.mem_addr      = r_addr;
    assign bus.mem_re        = (r_state == ST_READ);
    assign bus.mem_we        = (r_state == ST_WRITE) && r_step;
    assign bus.mem_wdata     = r_acc;
    assign bus.alu_a         = r_acc;
    assign bus.alu_increment = w_inc;
    assign bus.alu_decrement = w_dec;
    assign bus.alu_nochange  = !(w_inc || w_dec);
    assign bus.done          = w_done;
    assign bus.result        = w_done ? w_done_value : r_result;

endmodule

// File: tb/tb_bf_cell_sequencer.sv
// Self-checking bench for bf_cell_sequencer with a behavioural RAM and ALU.
// Honours CELL_SAT_EN the same way as the design build.
module tb_bf_cell_sequencer;
    import bf_cell_sequencer_pkg::*;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 15;
    localparam int CNT_W  = 8;
`ifdef CELL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        int         lat;
        logic [7:0] result;
        int         we;
        int         inc;
        int         dec;
        logic       sat;
    } exp_t;

    typedef struct {
        int         done_lat;
        int         re_cycle;
        int         we_cnt;
        int         we_cycle;
        int         inc;
        int         dec;
        int         ctrl_bad;
        int         busy_ready;
        int         ready_wait;
        logic [7:0] result;
        logic [7:0] wdata;
        logic       sat;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    bf_cell_sequencer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    bf_cell_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM with registered read, ALU purely combinational
    logic [7:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.alu_out = bus.alu_increment ? bus.alu_a + 8'd1 :
                         bus.alu_decrement ? bus.alu_a - 8'd1 : bus.alu_a;

    function automatic exp_t model(input logic [1:0] op, input logic [7:0] init, input int count);
        exp_t e;
        logic [7:0] a;
        bit step;
        a = init;
        e.inc = 0; e.dec = 0; e.sat = 1'b0;
        step = ((op == 2'b01) || (op == 2'b10)) && (count != 0);
        if (step) begin
            for (int i = 0; i < count; i++) begin
                if (op == 2'b01) begin
                    if (SAT && a == 8'hFF) e.sat = 1'b1;
                    else begin a = a + 8'd1; e.inc++; end
                end else begin
                    if (SAT && a == 8'h00) e.sat = 1'b1;
                    else begin a = a - 8'd1; e.dec++; end
                end
            end
        end
        e.result = a;
        e.we     = step ? 1 : 0;
        e.lat    = step ? count + 3 : 2;
        return e;
    endfunction

    // Drive one command (called at a negedge) and watch it until done plus one tail cycle.
    task automatic run_cmd(input logic [1:0] op, input logic [14:0] addr, input logic [7:0] count,
                           input bit hold, output obs_t o);
        o = '{default: 0};
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_count = count;
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && o.ready_wait < 20) begin
            @(negedge clk);
            o.ready_wait++;
        end
        @(posedge clk);
        #1;
        if (!hold) bus.cmd_valid = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (bus.mem_re === 1'b1 && o.re_cycle == 0) o.re_cycle = c;
            if (bus.mem_we === 1'b1) begin o.we_cnt++; o.we_cycle = c; o.wdata = bus.mem_wdata; end
            if (bus.alu_increment === 1'b1) o.inc++;
            if (bus.alu_decrement === 1'b1) o.dec++;
            if ($countones({bus.alu_increment, bus.alu_decrement, bus.alu_nochange}) != 1) o.ctrl_bad++;
            if (bus.cmd_ready !== 1'b0) o.busy_ready++;
            if (bus.done === 1'b1) begin
                o.done_lat = c;
                o.result   = bus.result;
                o.sat      = bus.sat_hit;
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        if (bus.mem_we === 1'b1) o.we_cnt++;
        $display("cmd op=%0d addr=%h cnt=%0d -> done@c%0d result=%h we=%0d sat=%0b",
                 op, addr, count, o.done_lat, o.result, o.we_cnt, o.sat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0; bus.cmd_count = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mem_re, bus.mem_we, bus.done, bus.alu_nochange, bus.alu_increment,
             bus.alu_decrement, bus.sat_hit} !== 7'b0001000)
            $display("FAIL reset_ctrl: got %b expected %b",
                     {bus.mem_re, bus.mem_we, bus.done, bus.alu_nochange, bus.alu_increment,
                      bus.alu_decrement, bus.sat_hit}, 7'b0001000);
        else passed++;
        checks++;
        if ({bus.mem_addr, bus.result, bus.alu_a} !== 31'd0)
            $display("FAIL reset_data: got addr=%h result=%h acc=%h expected 0", bus.mem_addr, bus.result, bus.alu_a);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready);
        else passed++;
    endtask

    task automatic test_inc_basic();
        obs_t o; exp_t e;
        ram[15'h10] = 8'h05;
        exp_q.push_back(model(2'b01, 8'h05, 3));
        run_cmd(2'b01, 15'h10, 8'd3, 1'b0, o);
        e = exp_q.pop_front();
        checks++; if (o.re_cycle !== 1) $display("FAIL inc_re_cycle: got %0d expected 1", o.re_cycle); else passed++;
        checks++; if (o.done_lat !== e.lat) $display("FAIL inc_latency: got %0d expected %0d", o.done_lat, e.lat); else passed++;
        checks++; if (o.we_cycle !== e.lat) $display("FAIL inc_we_cycle: got %0d expected %0d", o.we_cycle, e.lat); else passed++;
        checks++; if (o.wdata !== e.result) $display("FAIL inc_wdata: got %h expected %h", o.wdata, e.result); else passed++;
        checks++; if (o.result !== e.result) $display("FAIL inc_result: got %h expected %h", o.result, e.result); else passed++;
        checks++; if (o.inc !== e.inc) $display("FAIL inc_steps: got %0d expected %0d", o.inc, e.inc); else passed++;
        checks++; if (o.ctrl_bad !== 0) $display("FAIL inc_ctrl_onehot: got %0d bad cycles expected 0", o.ctrl_bad); else passed++;
        checks++; if (ram[15'h10] !== 8'h08) $display("FAIL inc_ram: got %h expected 08", ram[15'h10]); else passed++;
    endtask

    task automatic test_dec_wrap();
        obs_t o; exp_t e;
        ram[15'h20] = 8'h01;
        exp_q.push_back(model(2'b10, 8'h01, 2));
        run_cmd(2'b10, 15'h20, 8'd2, 1'b0, o);
        e = exp_q.pop_front();
        checks++; if (o.wdata !== e.result) $display("FAIL dec_wdata: got %h expected %h", o.wdata, e.result); else passed++;
        checks++; if (o.result !== e.result) $display("FAIL dec_result: got %h expected %h", o.result, e.result); else passed++;
        checks++; if (o.sat !== e.sat) $display("FAIL dec_sat_hit: got %b expected %b", o.sat, e.sat); else passed++;
        checks++; if (o.dec !== e.dec) $display("FAIL dec_steps: got %0d expected %0d", o.dec, e.dec); else passed++;
        checks++; if (o.done_lat !== e.lat) $display("FAIL dec_latency: got %0d expected %0d", o.done_lat, e.lat); else passed++;
    endtask

    task automatic test_skip();
        obs_t o; exp_t e;
        logic [1:0] ops [3];
        logic [7:0] cnts [3];
        ops[0] = 2'b01; cnts[0] = 8'd0;
        ops[1] = 2'b00; cnts[1] = 8'd5;
        ops[2] = 2'b11; cnts[2] = 8'd7;
        for (int k = 0; k < 3; k++) begin
            ram[15'h42] = 8'h42;
            exp_q.push_back(model(ops[k], 8'h42, int'(cnts[k])));
            run_cmd(ops[k], 15'h42, cnts[k], 1'b0, o);
            e = exp_q.pop_front();
            checks++; if (o.done_lat !== e.lat) $display("FAIL skip%0d_latency: got %0d expected %0d", k, o.done_lat, e.lat); else passed++;
            checks++; if (o.result !== e.result) $display("FAIL skip%0d_result: got %h expected %h", k, o.result, e.result); else passed++;
            checks++; if (o.we_cnt !== e.we) $display("FAIL skip%0d_we: got %0d expected %0d", k, o.we_cnt, e.we); else passed++;
            checks++; if (o.inc + o.dec + o.ctrl_bad !== 0) $display("FAIL skip%0d_alu_idle: got %0d active expected 0", k, o.inc + o.dec + o.ctrl_bad); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2; exp_t e;
        ram[15'h30] = 8'h7F;
        exp_q.push_back(model(2'b01, 8'h7F, 1));
        exp_q.push_back(model(2'b10, 8'h80, 1));
        run_cmd(2'b01, 15'h30, 8'd1, 1'b0, o1);
        run_cmd(2'b10, 15'h30, 8'd1, 1'b0, o2);
        e = exp_q.pop_front();
        checks++; if (o1.result !== e.result) $display("FAIL b2b_first_result: got %h expected %h", o1.result, e.result); else passed++;
        checks++; if (o1.we_cycle !== e.lat) $display("FAIL b2b_first_we_cycle: got %0d expected %0d", o1.we_cycle, e.lat); else passed++;
        e = exp_q.pop_front();
        checks++; if (o2.ready_wait !== 0) $display("FAIL b2b_accept_gap: got %0d wait cycles expected 0", o2.ready_wait); else passed++;
        checks++; if (o2.result !== e.result) $display("FAIL b2b_second_result: got %h expected %h", o2.result, e.result); else passed++;
        checks++; if (ram[15'h30] !== 8'h7F) $display("FAIL b2b_ram: got %h expected 7f", ram[15'h30]); else passed++;
    endtask

    task automatic test_reset_mid_apply();
        obs_t o; exp_t e;
        int we_seen;
        we_seen = 0;
        ram[15'h50] = 8'h10;
        bus.cmd_op = 2'b01; bus.cmd_addr = 15'h50; bus.cmd_count = 8'd200; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) we_seen++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_re, bus.mem_we, bus.done, bus.alu_nochange, bus.alu_increment,
             bus.alu_decrement, bus.sat_hit, bus.cmd_ready} !== 8'b00010001)
            $display("FAIL abort_ctrl: got %b expected %b",
                     {bus.mem_re, bus.mem_we, bus.done, bus.alu_nochange, bus.alu_increment,
                      bus.alu_decrement, bus.sat_hit, bus.cmd_ready}, 8'b00010001);
        else passed++;
        checks++;
        if ({bus.mem_addr, bus.alu_a, bus.result} !== 31'd0)
            $display("FAIL abort_data: got addr=%h acc=%h result=%h expected 0", bus.mem_addr, bus.alu_a, bus.result);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (we_seen + int'(ram[15'h50] !== 8'h10) !== 0)
            $display("FAIL abort_no_write: got we=%0d ram=%h expected we=0 ram=10", we_seen, ram[15'h50]);
        else passed++;
        exp_q.push_back(model(2'b01, 8'h10, 4));
        run_cmd(2'b01, 15'h50, 8'd4, 1'b0, o);
        e = exp_q.pop_front();
        checks++; if (o.result !== e.result) $display("FAIL after_abort_result: got %h expected %h", o.result, e.result); else passed++;
        checks++; if (o.done_lat !== e.lat) $display("FAIL after_abort_latency: got %0d expected %0d", o.done_lat, e.lat); else passed++;
    endtask

    task automatic test_long_hold();
        obs_t o; exp_t e;
        ram[15'h0] = 8'h00;
        exp_q.push_back(model(2'b01, 8'h00, 255));
        run_cmd(2'b01, 15'h0, 8'd255, 1'b1, o);
        e = exp_q.pop_front();
        checks++; if (o.done_lat !== e.lat) $display("FAIL long_latency: got %0d expected %0d", o.done_lat, e.lat); else passed++;
        checks++; if (o.wdata !== e.result) $display("FAIL long_wdata: got %h expected %h", o.wdata, e.result); else passed++;
        checks++; if (o.busy_ready !== 0) $display("FAIL long_no_reaccept: got %0d ready cycles expected 0", o.busy_ready); else passed++;
        checks++; if (o.we_cnt !== e.we) $display("FAIL long_we_count: got %0d expected %0d", o.we_cnt, e.we); else passed++;
    endtask

    task automatic test_random();
        obs_t o; exp_t e;
        logic [1:0]  op;
        logic [14:0] addr;
        logic [7:0]  val, cnt;
        for (int k = 0; k < 8; k++) begin
            op   = 2'($urandom_range(0, 3));
            addr = 15'($urandom_range(0, 32767));
            val  = 8'($urandom_range(0, 255));
            cnt  = 8'($urandom_range(0, 6));
            if (k == 0) val = 8'hFE;
            ram[addr] = val;
            exp_q.push_back(model(op, val, int'(cnt)));
            run_cmd(op, addr, cnt, 1'b0, o);
            e = exp_q.pop_front();
            checks++;
            if (o.result !== e.result || o.done_lat !== e.lat || o.sat !== e.sat || ram[addr] !== e.result)
                $display("FAIL rand%0d: got result=%h lat=%0d sat=%b ram=%h expected result=%h lat=%0d sat=%b",
                         k, o.result, o.done_lat, o.sat, ram[addr], e.result, e.lat, e.sat);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_inc_basic();
        test_dec_wrap();
        test_skip();
        test_back_to_back();
        test_reset_mid_apply();
        test_long_hold();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
